// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction fetch front end. It issues FETCH_W-wide requests to a
// 1-cycle-latency synchronous instruction memory and buffers the returned
// words, each tagged with its PC, in a circular queue. Decode reads the
// oldest FETCH_W entries combinationally and consumes 0..FETCH_W of them
// per cycle. A redirect flushes the queue and restarts fetch at a new PC.
//
// Requests are credit-limited: a request is only issued when the queue is
// guaranteed to have room for its response on top of the current
// occupancy and the response already in flight. An accepted response
// therefore never overflows the queue.
//
// Optional feature (compile-time macro):
//   FETCH_ALIGN_EN  - when defined, a fetch group is truncated at the next
//                     FETCH_W*4-byte boundary. Only the first n slots are
//                     enqueued, with n = FETCH_W - ((fetch_pc>>2) mod FETCH_W).
//                     When undefined, every group carries FETCH_W words.
//
// Ports:
//   clk          in   clock; all state updates on the rising edge
//   reset        in   asynchronous, active-low reset
//   fetch_en     in   permission to issue new memory requests
//   redirect_en  in   flush the queue and restart fetch at redirect_pc
//   redirect_pc  in   new fetch address; bits [1:0] are ignored
//   imem_ren     out  memory read request this cycle
//   imem_addr    out  per-slot byte address, fetch_pc + 4*i
//   imem_rdata   in   read data, valid the cycle after imem_ren
//   out_valid    out  thermometer valid, out_valid[i] = (i < occupancy)
//   out_pc       out  PCs of the oldest FETCH_W entries, slot 0 oldest
//   out_instr    out  instructions of the oldest FETCH_W entries
//   deq_cnt      in   entries consumed by decode this cycle (clamped)
//   occupancy    out  current number of valid entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int               FETCH_W     = 2,
    parameter int               PC_W        = 32,
    parameter int               INSTR_W     = 32,
    parameter int               QUEUE_DEPTH = 8,
    parameter logic [PC_W-1:0]  RESET_PC    = '0,
    localparam int              CNT_W       = $clog2(FETCH_W + 1),
    localparam int              OCC_W       = $clog2(QUEUE_DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             fetch_en,
    input  logic                             redirect_en,
    input  logic [PC_W-1:0]                  redirect_pc,
    output logic                             imem_ren,
    output logic [FETCH_W-1:0][PC_W-1:0]     imem_addr,
    input  logic [FETCH_W-1:0][INSTR_W-1:0]  imem_rdata,
    output logic [FETCH_W-1:0]               out_valid,
    output logic [FETCH_W-1:0][PC_W-1:0]     out_pc,
    output logic [FETCH_W-1:0][INSTR_W-1:0]  out_instr,
    input  logic [CNT_W-1:0]                 deq_cnt,
    output logic [OCC_W-1:0]                 occupancy
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);

    // Queue storage. Reads are combinational because decode sees the head
    // entries in the same cycle; slots past occupancy are masked by out_valid.
    logic [PC_W-1:0]    pc_mem    [QUEUE_DEPTH];
    logic [INSTR_W-1:0] instr_mem [QUEUE_DEPTH];

    logic [PTR_W-1:0] head_reg,    head_next;
    logic [PTR_W-1:0] tail_reg,    tail_next;
    logic [OCC_W-1:0] occ_reg,     occ_next;
    logic [PC_W-1:0]  pc_reg,      pc_next;
    // Size of the group requested last cycle; zero means nothing in flight.
    logic [CNT_W-1:0] pend_n_reg,  pend_n_next;
    logic [PC_W-1:0]  pend_pc_reg, pend_pc_next;

    logic [CNT_W-1:0] grp_n;
    logic [CNT_W-1:0] n_enq;
    logic [OCC_W-1:0] deq_eff;
    logic [OCC_W:0]   used;

    // ------------------------------------------------------------------
    // Group size of the request that would be issued this cycle
    // ------------------------------------------------------------------
`ifdef FETCH_ALIGN_EN
    logic [PC_W-1:0] word_idx;
    always_comb begin
        word_idx = pc_reg >> 2;
        grp_n    = CNT_W'(FETCH_W) - CNT_W'(word_idx % PC_W'(FETCH_W));
    end
`else
    assign grp_n = CNT_W'(FETCH_W);
`endif

    // ------------------------------------------------------------------
    // Request credit, enqueue/dequeue counts
    // ------------------------------------------------------------------
    always_comb begin
        // Space is reserved for a full FETCH_W group regardless of the
        // actual group size, which keeps the check independent of grp_n.
        used     = (OCC_W+1)'(occ_reg) + (OCC_W+1)'(pend_n_reg);
        // reset gates the request so it drops the instant reset asserts.
        imem_ren = reset && fetch_en && !redirect_en &&
                   (used <= (OCC_W+1)'(QUEUE_DEPTH - FETCH_W));

        // A redirect discards the response to last cycle's request.
        n_enq    = redirect_en ? '0 : pend_n_reg;

        if (redirect_en) begin
            deq_eff = '0;
        end else if (OCC_W'(deq_cnt) > occ_reg) begin
            deq_eff = occ_reg;
        end else begin
            deq_eff = OCC_W'(deq_cnt);
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        head_next    = head_reg + PTR_W'(deq_eff);
        tail_next    = tail_reg + PTR_W'(n_enq);
        occ_next     = occ_reg + OCC_W'(n_enq) - deq_eff;
        pc_next      = pc_reg;
        pend_n_next  = '0;
        pend_pc_next = pend_pc_reg;

        if (redirect_en) begin
            // Flush: the queue empties by moving head onto tail.
            head_next = tail_reg;
            occ_next  = '0;
            pc_next   = redirect_pc & ~PC_W'(3);
        end else if (imem_ren) begin
            pc_next      = pc_reg + (PC_W'(grp_n) << 2);
            pend_n_next  = grp_n;
            pend_pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg    <= '0;
            tail_reg    <= '0;
            occ_reg     <= '0;
            pc_reg      <= RESET_PC;
            pend_n_reg  <= '0;
            pend_pc_reg <= '0;
        end else begin
            head_reg    <= head_next;
            tail_reg    <= tail_next;
            occ_reg     <= occ_next;
            pc_reg      <= pc_next;
            pend_n_reg  <= pend_n_next;
            pend_pc_reg <= pend_pc_next;
        end
    end

    // Response words land at tail the cycle after the request. Slot i of
    // the group belongs to PC pend_pc + 4*i.
    always_ff @(posedge clk) begin
        for (int i = 0; i < FETCH_W; i++) begin
            if (i < int'(n_enq)) begin
                pc_mem[tail_reg + PTR_W'(i)]    <= pend_pc_reg + PC_W'(4 * i);
                instr_mem[tail_reg + PTR_W'(i)] <= imem_rdata[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-slot outputs
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < FETCH_W; gi++) begin : g_slot
            logic [PTR_W-1:0] rd_idx;
            assign rd_idx        = head_reg + PTR_W'(gi);
            assign out_valid[gi] = OCC_W'(gi) < occ_reg;
            assign out_pc[gi]    = pc_mem[rd_idx];
            assign out_instr[gi] = instr_mem[rd_idx];
            assign imem_addr[gi] = pc_reg + PC_W'(4 * gi);
        end
    endgenerate

    assign occupancy = occ_reg;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter FETCH_W, default 2, meaning instructions per fetch group (legal 1..4).
REQ-002 SHALL have parameter PC_W, default 32, meaning PC width in bits.
REQ-003 SHALL have parameter INSTR_W, default 32, meaning instruction width in bits.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 8, meaning instruction-queue entries (power of two, >= 2*FETCH_W).
REQ-005 SHALL have parameter RESET_PC, default 0, meaning first fetch address after reset.
REQ-006 SHALL have port clk  in  1  meaning the single clock; all state updates on rising edge.
REQ-007 SHALL have port reset  in  1  meaning asynchronous, active-low reset (0 = in reset).
REQ-008 SHALL have port fetch_en  in  1  meaning permission to issue new memory requests.
REQ-009 SHALL have port redirect_en  in  1  meaning flush and restart fetch at redirect_pc.
REQ-010 SHALL have port redirect_pc  in  PC_W  meaning new fetch address; bits [1:0] ignored.
REQ-011 SHALL have port imem_ren  out  1  meaning memory read request this cycle.
REQ-012 SHALL have port imem_addr  out  FETCH_W x PC_W  meaning per-slot byte address, imem_addr[i] = fetch_pc + 4*i.
REQ-013 SHALL have port imem_rdata  in  FETCH_W x INSTR_W  meaning read data, valid the cycle after imem_ren (1-cycle synchronous memory).
REQ-014 SHALL have port out_valid  out  FETCH_W  meaning thermometer-coded valid; out_valid[i] = (i < occupancy).
REQ-015 SHALL have port out_pc / out_instr  out  FETCH_W x PC_W / FETCH_W x INSTR_W  meaning oldest FETCH_W entries, slot 0 oldest.
REQ-016 SHALL have port deq_cnt  in  clog2(FETCH_W+1)  meaning entries consumed by decode this cycle.
REQ-017 SHALL have port occupancy  out  clog2(QUEUE_DEPTH+1)  meaning current valid entries.

Function
REQ-018 SHALL hold a circular queue with head/tail pointers modulo QUEUE_DEPTH; out_* driven combinationally from registered entries at head.
REQ-019 SHALL assert imem_ren when fetch_en=1, redirect_en=0, and QUEUE_DEPTH - occupancy - pending >= FETCH_W, pending = entries reserved by a request issued the previous cycle.
REQ-020 SHALL, on each issued request, advance fetch_pc by 4*n, n = entries in the group (see REQ-029); back-to-back issue every cycle allowed.
REQ-021 SHALL write the n response words at tail the cycle after the request; PC issued in cycle t appears on out_valid in cycle t+2.
REQ-022 SHALL apply enqueue and dequeue in the same cycle; occupancy_next = occupancy + n_enq - deq_cnt.
REQ-023 SHALL clamp deq_cnt to current occupancy; excess is ignored, never underflows.
REQ-024 SHALL, with fetch_en=0, issue no requests but still enqueue an already in-flight response.
REQ-025 SHALL, in a cycle with redirect_en=1: set occupancy 0 and head=tail next cycle, ignore deq_cnt, issue no request, load fetch_pc = {redirect_pc[PC_W-1:2],2'b00}, and discard the response of any request issued the previous cycle.
REQ-026 SHALL resume requests the cycle after redirect; consecutive redirects each take effect, last wins.
REQ-027 SHALL never overflow: credit rule of REQ-019 guarantees space for every accepted response.

Reset
REQ-028 SHALL, while reset=0 (asynchronously): occupancy 0, head/tail 0, pending 0, fetch_pc=RESET_PC, out_valid all 0, imem_ren 0; in-flight responses discarded; first request in the first cycle after release with fetch_en=1.

Configuration
REQ-029 SHALL honour macro FETCH_ALIGN_EN: when defined, n = FETCH_W - ((fetch_pc>>2) mod FETCH_W) (group truncated at FETCH_W*4-byte boundary, only first n slots enqueued); when undefined, n = FETCH_W always.

Verification (FETCH_W=2, QUEUE_DEPTH=8, RESET_PC=0, mem word k at PC 4k = 0x11111111*(k+1) for k<6)
REQ-030 SHALL cover: release reset, fetch_en=1, deq_cnt=2 -> cycle 2 out_valid=11, PC 0x00/0x04, instr 0x11111111/0x22222222; then 0x08/0x0C next cycle, one group per cycle.
REQ-031 SHALL cover: deq_cnt=0 sustained -> occupancy stops at 8, imem_ren low thereafter; then deq_cnt=2 -> order 0x00,0x04,... preserved, no loss.
REQ-032 SHALL cover: deq_cnt=1 with occupancy 2 at PC 0x00/0x04 -> next cycle out_pc[0]=0x04, occupancy reflects simultaneous enqueue.
REQ-033 SHALL cover: redirect to 0x08 with a request in flight -> occupancy 0 next cycle, stale data never visible, first group PC 0x08/0x0C instr 0x33333333/0x44444444.
REQ-034 SHALL cover: redirect to 0x04 -> with FETCH_ALIGN_EN first group out_valid=01 PC 0x04, next 0x08/0x0C; without it first group 0x04/0x08.
REQ-035 SHALL cover: reset driven 0 mid-stream between edges -> out_valid=00, imem_ren=0 immediately; after release fetch restarts at 0x00.
